// File: rtl/mips_cpu_bus_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU control codes,
// the sequencer state type and small op-classification helpers.
package mips_cpu_bus_hilo_pkg;

    localparam logic [4:0] ALU_MULT  = 5'd8;
    localparam logic [4:0] ALU_MULTU = 5'd7;
    localparam logic [4:0] ALU_DIV   = 5'd5;
    localparam logic [4:0] ALU_DIVU  = 5'd4;
    localparam logic [4:0] ALU_MTLO  = 5'd18;
    localparam logic [4:0] ALU_MTHI  = 5'd19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } hilo_state_t;

    // True for the four iterative operations.
    function automatic logic is_muldiv_op(input logic [4:0] code);
        case (code)
            ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // True for the codes that take the signed (magnitude + sign flag) path.
    function automatic logic is_signed_op(input logic [4:0] code);
        case (code)
            ALU_MULT, ALU_DIV: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_bus_seq_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module mips_cpu_bus_seq_divider #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    logic [W-1:0] quo_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] dsr_q;
    logic [W:0]   shifted_s;
    logic [W-1:0] rem_sub_s;
    logic         fits_s;

    // Trial subtraction of the divisor from the partial remainder shifted left by one.
    always_comb begin
        shifted_s = {rem_q, quo_q[W-1]};
        fits_s    = (shifted_s >= {1'b0, dsr_q});
        rem_sub_s = shifted_s[W-1:0] - dsr_q;
    end

    // Quotient/remainder shift registers: load on a new divide, advance one bit per step.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_q <= {W{1'b0}};
            rem_q <= {W{1'b0}};
            dsr_q <= {W{1'b0}};
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= {W{1'b0}};
            dsr_q <= divisor_i;
        end else if (step_i) begin
            if (fits_s) begin
                rem_q <= rem_sub_s;
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted_s[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mips_cpu_bus_hilo_unit.sv
// Iterative multiply/divide unit owning HI/LO. Multiplies are shift-add on a
// 64-bit accumulator; divides use the sequential restoring divider. Signed
// ops run on magnitudes and get their signs restored in the FIXUP cycle.
module mips_cpu_bus_hilo_unit
    import mips_cpu_bus_hilo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    input  logic                  mf_req,
    input  logic                  mf_hi_sel,
    output logic [DATA_WIDTH-1:0] mf_data,
    output logic                  mf_stall
);

    localparam int              W     = DATA_WIDTH;
    localparam int              CW    = $clog2(ITERATIONS);
    localparam logic [CW-1:0]   LAST  = CW'(ITERATIONS - 1);
    localparam logic [W-1:0]    ONE   = W'(1);
    localparam logic [2*W-1:0]  ONE2  = (2*W)'(1);

    hilo_state_t    state_q, state_d;
    logic [CW-1:0]  count_q;
    logic           is_div_q, neg_q, neg_rem_q, dbz_q, done_q;
    logic [W-1:0]   mcand_q, hi_q, lo_q;
    logic [2*W-1:0] acc_q;

    logic           accept_s, muldiv_go_s, signed_s, div_load_s, div_step_s;
    logic [W-1:0]   abs_a_s, abs_b_s;
    logic [W:0]     mul_sum_s;
    logic [2*W-1:0] acc_step_s, prod_fix_s;
    logic [W-1:0]   div_quo_s, div_rem_s, quo_fix_s, rem_fix_s;

    // Request acceptance and operand magnitude preparation.
    always_comb begin
        accept_s    = start && (state_q == IDLE);
        muldiv_go_s = accept_s && is_muldiv_op(op);
        signed_s    = is_signed_op(op);
        abs_a_s     = (signed_s && op_a[W-1]) ? (~op_a + ONE) : op_a;
        abs_b_s     = (signed_s && op_b[W-1]) ? (~op_b + ONE) : op_b;
        div_load_s  = muldiv_go_s && ((op == ALU_DIV) || (op == ALU_DIVU));
        div_step_s  = (state_q == RUN) && is_div_q;
    end

    // One shift-add multiply step; the multiplier sits in the low half and shifts out.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        acc_step_s = {mul_sum_s, acc_q[W-1:1]};
    end

    // Sign restoration; a zero divisor forces LO to all-ones and leaves HI = dividend.
    always_comb begin
        prod_fix_s = neg_q ? (~acc_q + ONE2) : acc_q;
        rem_fix_s  = neg_rem_q ? (~div_rem_s + ONE) : div_rem_s;
        if (dbz_q) begin
            quo_fix_s = {W{1'b1}};
        end else if (neg_q) begin
            quo_fix_s = ~div_quo_s + ONE;
        end else begin
            quo_fix_s = div_quo_s;
        end
    end

    mips_cpu_bus_seq_divider #(.W(W)) u_div (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (div_load_s),
        .step_i      (div_step_s),
        .dividend_i  (abs_a_s),
        .divisor_i   (abs_b_s),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s)
    );

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = muldiv_go_s ? RUN : IDLE;
            RUN:     state_d = (count_q == LAST) ? FIXUP : RUN;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operand latch, iteration, HI/LO writes and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            mcand_q   <= {W{1'b0}};
            acc_q     <= {(2*W){1'b0}};
            hi_q      <= {W{1'b0}};
            lo_q      <= {W{1'b0}};
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_s && (op == ALU_MTHI)) begin
                hi_q <= op_a;
            end
            if (accept_s && (op == ALU_MTLO)) begin
                lo_q <= op_a;
            end
            if (muldiv_go_s) begin
                count_q   <= {CW{1'b0}};
                is_div_q  <= (op == ALU_DIV) || (op == ALU_DIVU);
                neg_q     <= signed_s && (op_a[W-1] ^ op_b[W-1]);
                neg_rem_q <= signed_s && op_a[W-1];
                dbz_q     <= (op_b == {W{1'b0}});
                mcand_q   <= abs_a_s;
                acc_q     <= {{W{1'b0}}, abs_b_s};
            end
            if (state_q == RUN) begin
                count_q <= count_q + CW'(1);
                if (!is_div_q) begin
                    acc_q <= acc_step_s;
                end
            end
            if (state_q == FIXUP) begin
                done_q <= 1'b1;
                if (is_div_q) begin
                    hi_q <= rem_fix_s;
                    lo_q <= quo_fix_s;
                end else begin
                    hi_q <= prod_fix_s[2*W-1:W];
                    lo_q <= prod_fix_s[W-1:0];
                end
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign mf_data  = mf_hi_sel ? hi_q : lo_q;
    assign mf_stall = mf_req & busy;

endmodule

// File: tb/tb_mips_cpu_bus_hilo_unit.sv
// Self-checking bench for mips_cpu_bus_hilo_unit: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_mips_cpu_bus_hilo_unit;
    import mips_cpu_bus_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, mf_req, mf_hi_sel;
    logic [4:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, done, mf_stall;
    logic [31:0] hi, lo, mf_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    mips_cpu_bus_hilo_unit #(.DATA_WIDTH(32), .ITERATIONS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .mf_req    (mf_req),
        .mf_hi_sel (mf_hi_sel),
        .mf_data   (mf_data),
        .mf_stall  (mf_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void ref_model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = m_hi;
        rl = m_lo;
        case (o)
            ALU_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            ALU_MULT: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            ALU_DIVU: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = 32'hFFFFFFFF;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            ALU_DIV: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = 32'hFFFFFFFF;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
            default: begin
                rh = m_hi;
                rl = m_lo;
            end
        endcase
    endfunction

    // Issue one mult/div, optionally pulse an MTHI at busy cycle inj, and check the result.
    task automatic run_muldiv(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int inj, input string tag);
        logic [31:0] eh, el;
        int n;
        ref_model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (mf_req) chk({tag, "_stall"}, 64'(mf_stall), 64'd1);
            n++;
            if (n == inj) begin
                start = 1'b1; op = ALU_MTHI; op_a = 32'h00000055;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        if (mf_req) chk({tag, "_stall_rel"}, 64'(mf_stall), 64'd0);
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    // MTHI/MTLO write while idle, then read both registers back through mf_data.
    task automatic do_move(input logic [4:0] o, input logic [31:0] a, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a;
        @(negedge clk);
        start = 1'b0;
        if (o == ALU_MTHI) m_hi = a;
        else m_lo = a;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        mf_hi_sel = 1'b1;
        #1 chk({tag, "_mfhi"}, 64'(mf_data), 64'(m_hi));
        mf_hi_sel = 1'b0;
        #1 chk({tag, "_mflo"}, 64'(mf_data), 64'(m_lo));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ops[6];
        logic [31:0] ra, rb;
        int          k;
        ops[0] = ALU_MULT; ops[1] = ALU_MULTU; ops[2] = ALU_DIV;
        ops[3] = ALU_DIVU; ops[4] = ALU_MTHI;  ops[5] = ALU_MTLO;

        reset = 1'b1; start = 1'b0; op = 5'd0; op_a = 32'd0; op_b = 32'd0;
        mf_req = 1'b1; mf_hi_sel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(mf_stall), 64'd0);

        // Directed cases with spec constants checked directly as well.
        run_muldiv(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
        chk("multu_max_hik", 64'(hi), 64'hFFFFFFFE);
        chk("multu_max_lok", 64'(lo), 64'h00000001);
        mf_req = 1'b0;
        run_muldiv(ALU_MULT, 32'hFFFFFFFD, 32'd5, 0, "mult_neg");
        chk("mult_neg_lok", 64'(lo), 64'hFFFFFFF1);
        run_muldiv(ALU_DIV, 32'hFFFFFFF9, 32'd2, 0, "div_neg");
        chk("div_neg_lok", 64'(lo), 64'hFFFFFFFD);
        chk("div_neg_hik", 64'(hi), 64'hFFFFFFFF);
        run_muldiv(ALU_DIVU, 32'd7, 32'd2, 0, "divu_7_2");
        run_muldiv(ALU_DIVU, 32'h00001234, 32'd0, 0, "divu_zero");
        chk("divu_zero_lok", 64'(lo), 64'hFFFFFFFF);
        run_muldiv(ALU_DIV, 32'hFFFFFFF9, 32'd0, 0, "div_zero");
        run_muldiv(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        chk("div_ovf_lok", 64'(lo), 64'h80000000);

        // MTLO while idle, observed on mf_data; same-cycle read returns the old value.
        @(negedge clk);
        start = 1'b1; op = ALU_MTLO; op_a = 32'hDEADBEEF;
        mf_req = 1'b1; mf_hi_sel = 1'b0;
        #1 chk("mtlo_old", 64'(mf_data), 64'(m_lo));
        @(negedge clk);
        start = 1'b0;
        m_lo = 32'hDEADBEEF;
        chk("mtlo_lo", 64'(lo), 64'hDEADBEEF);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);
        chk("mtlo_mf", 64'(mf_data), 64'hDEADBEEF);
        chk("mtlo_stall", 64'(mf_stall), 64'd0);
        @(negedge clk);
        start = 1'b1; op = ALU_MTHI; op_a = 32'h0BADF00D; mf_hi_sel = 1'b1;
        #1 chk("mthi_old", 64'(mf_data), 64'(m_hi));
        @(negedge clk);
        start = 1'b0;
        m_hi = 32'h0BADF00D;
        chk("mthi_new", 64'(mf_data), 64'h0BADF00D);

        // MULTU with a stalled read and an MTHI attempt mid-operation.
        run_muldiv(ALU_MULTU, 32'h12345678, 32'h9ABCDEF0, 5, "multu_inj");
        mf_req = 1'b0;

        // Illegal codes are ignored.
        @(negedge clk);
        start = 1'b1; op = 5'd0; op_a = 32'hCAFE0001; op_b = 32'd3;
        @(negedge clk);
        op = 5'd31;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_busy", 64'(busy), 64'd0);
        chk("illegal_hi", 64'(hi), 64'(m_hi));
        chk("illegal_lo", 64'(lo), 64'(m_lo));

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        start = 1'b1; op = ALU_DIV; op_a = 32'hFFFFFFF9; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) chk("midrst_quiet", {62'd0, busy, done}, 64'd0);
            @(negedge clk);
        end
        run_muldiv(ALU_MULTU, 32'd3, 32'd4, 0, "multu_3_4");
        chk("multu_3_4_lok", 64'(lo), 64'd12);

        // Random mix of all legal operations.
        for (int i = 0; i < 24; i++) begin
            k  = int'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h80000000;
                default: ;
            endcase
            if (k >= 4) do_move(ops[k], ra, "rnd_mv");
            else run_muldiv(ops[k], ra, rb, 0, "rnd_op");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
